minitb_ahb_slave: RTL and testbench
===================================

# minitb_ahb_slave

AHB-Lite single-slave memory responder for miniTB benches; it is the target that a miniTB AHB master drives. It decodes pipelined address/data phases and stores writes in a small internal word memory. It returns read data with a programmable number of wait states, and answers out-of-range addresses with the two-cycle ERROR response. Synthesizable RTL, single clock, no arbitration (sole slave on the bus; its `hready` is the bus `hready`).

## Interface
- `addrWidth`, default 8: width of `haddr`. Word address; no byte lanes, no `hsize`.
- `dataWidth`, default 32: width of `hwdata` and `hrdata`.
- `memDepth`, default 16: number of words implemented. Legal addresses are 0..memDepth-1. Constraint: memDepth <= 2**addrWidth.
- `waitStates`, default 0: hready-low cycles inserted in every OKAY data phase. Range 0..15.

Ports:
- `hclk`, input, 1: bus clock. All state updates on the rising edge.
- `hreset`, input, 1: asynchronous, active-high reset.
- `htrans`, input, 2: transfer type. IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- `haddr`, input, addrWidth: address-phase address.
- `hwrite`, input, 1: 1 = write, 0 = read. Address phase.
- `hwdata`, input, dataWidth: write data. Data phase.
- `hready`, output, 1: 1 = current data phase completes at this edge.
- `hresp`, output, 1: 0 = OKAY, 1 = ERROR.
- `hrdata`, output, dataWidth: read data.

## Operation
- Transfer accepted at a rising `hclk` edge when `hready`=1 and `htrans[1]`=1 (NONSEQ or SEQ, treated identically). On acceptance, capture `addr_q`, `write_q`.
- IDLE/BUSY, or any `htrans` while `hready`=0: ignored, no transfer.
- States (registered; outputs decoded from registered state only):
  - S_IDLE: `hready`=1, `hresp`=0, `hrdata`=0.
  - S_WAIT: `hready`=0, `hresp`=0. `cnt` counts down from waitStates.
  - S_DATA: `hready`=1, `hresp`=0. For reads, `hrdata` = read word; for writes, `hrdata`=0.
  - S_ERR1: `hready`=0, `hresp`=1, `hrdata`=0.
  - S_ERR2: `hready`=1, `hresp`=1, `hrdata`=0.
- Transitions out of S_IDLE, S_DATA and S_ERR2 (all with `hready`=1):
  - Accepted transfer with `haddr` >= memDepth: go to S_ERR1.
  - Accepted transfer, in range, waitStates=0: go to S_DATA.
  - Accepted transfer, in range, waitStates>0: go to S_WAIT with `cnt`=waitStates.
  - No transfer: go to S_IDLE.
- S_WAIT: decrement `cnt`; go to S_DATA when `cnt`=1.
- S_ERR1 always goes to S_ERR2.
- Write commit: at the rising edge ending S_DATA for a write, `mem[addr_q]` <= `hwdata`. ERROR transfers never write memory.
- Read data: `hrdata` loads `mem[addr]` on the edge entering S_DATA, and returns to 0 on the edge leaving S_DATA.
- Forwarding: a read entering S_DATA on the same edge a write to the same address commits returns the new `hwdata`, not the stale word.
- Memory: memDepth x dataWidth register array, cleared to 0 by `hreset`.

## Timing
- Reset: immediate (asynchronous) on `hreset`=1.
  - State S_IDLE, `hready`=1, `hresp`=0, `hrdata`=0, `cnt`=0, memory all zero.
  - Reset mid-transfer discards the pending write and aborts any wait or error sequence.
- Latency, waitStates=0: address accepted at edge N; data phase completes at edge N+1. Back-to-back transfers sustain one per cycle with `hready` held at 1.
- Latency, waitStates=W>0: `hready` is low for exactly W cycles after the address edge. The data phase completes at edge N+W+1. The next address is sampled at that same edge.
- ERROR: `hready` low for exactly 1 cycle with `hresp`=1, then 1 cycle with `hready`=1 and `hresp`=1. This is independent of waitStates.
- `hwdata` is sampled only at the completing edge; values during wait cycles are don't-care.
- Outputs change only after rising `hclk` edges or on `hreset`, so a master driving on the falling edge sees stable values.

## Test plan
- Reset: assert `hreset` mid-simulation → `hready`=1, `hresp`=0, `hrdata`=0 immediately; a later read of 0x0 returns 0x00000000.
- waitStates=0: write 0x3 <= 0xDEADBEEF, then read 0x3 in the next cycle (pipelined) → read data phase shows `hrdata`=0xDEADBEEF via forwarding; `hready` never low.
- waitStates=2: write 0x5 <= 0x12345678, then read 0x5 → `hready` low exactly 2 cycles per transfer; `hrdata`=0x12345678 on the read's completing cycle, 0 otherwise.
- memDepth=16: write 0x20 <= 0xFFFFFFFF → one cycle with `hready`=0/`hresp`=1, then one with `hready`=1/`hresp`=1; reading 0x0..0xF afterwards shows no change.
- `htrans` BUSY then IDLE with arbitrary `haddr`/`hwrite` → state stays S_IDLE, `hready`=1, memory unchanged.
- waitStates=3: assert `hreset` during the second wait cycle of a write to 0x7 ← 0xA5A5A5A5 → `hready`=1 at once; a later read of 0x7 returns 0.

Source files
------------

// File: rtl/minitb_ahb_slave.sv
// AHB-Lite single-slave word memory with programmable wait states.
// Out-of-range addresses get the two-cycle ERROR response and never touch memory.
module minitb_ahb_slave #(
    parameter int addrWidth  = 8,
    parameter int dataWidth  = 32,
    parameter int memDepth   = 16,
    parameter int waitStates = 0
) (
    input  logic                 hclk,
    input  logic                 hreset,
    input  logic [1:0]           htrans,
    input  logic [addrWidth-1:0] haddr,
    input  logic                 hwrite,
    input  logic [dataWidth-1:0] hwdata,
    output logic                 hready,
    output logic                 hresp,
    output logic [dataWidth-1:0] hrdata
);
    localparam int IDX_W = (memDepth > 1) ? $clog2(memDepth) : 1;
    localparam logic [addrWidth:0] DEPTH = (addrWidth + 1)'(memDepth);
    localparam logic [3:0] WS = 4'(waitStates);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    state_t               state, state_n;
    logic [3:0]           cnt, cnt_n;
    logic [IDX_W-1:0]     addr_q;
    logic                 write_q;
    logic [dataWidth-1:0] mem [memDepth];

    logic                 accept, in_range, rd_wr, fwd;
    logic [IDX_W-1:0]     rd_idx;
    logic [dataWidth-1:0] rd_word;

    assign hready = !(state == S_WAIT || state == S_ERR1);
    assign hresp  = (state == S_ERR1 || state == S_ERR2);

    always_comb begin
        accept   = hready && htrans[1];
        in_range = {1'b0, haddr} < DEPTH;
        state_n  = state;
        cnt_n    = cnt;
        case (state)
            S_WAIT: begin
                cnt_n = cnt - 4'd1;
                if (cnt == 4'd1) state_n = S_DATA;
            end
            S_ERR1: state_n = S_ERR2;
            default: begin
                if (!accept)        state_n = S_IDLE;
                else if (!in_range) state_n = S_ERR1;
                else if (WS == 4'd0) state_n = S_DATA;
                else begin
                    state_n = S_WAIT;
                    cnt_n   = WS;
                end
            end
        endcase
    end

    // The read address comes from the bus on a zero-wait entry, from addr_q after waits.
    // A write committing on the same edge is forwarded so the read never sees the stale word.
    always_comb begin
        rd_idx  = (state == S_WAIT) ? addr_q : haddr[IDX_W-1:0];
        rd_wr   = (state == S_WAIT) ? write_q : hwrite;
        fwd     = (state == S_DATA) && write_q && (addr_q == rd_idx);
        rd_word = fwd ? hwdata : mem[rd_idx];
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            hrdata  <= '0;
            for (int i = 0; i < memDepth; i++) mem[i] <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= haddr[IDX_W-1:0];
                write_q <= hwrite;
            end
            if (state == S_DATA && write_q) mem[addr_q] <= hwdata;
            hrdata <= (state_n == S_DATA && !rd_wr) ? rd_word : '0;
        end
    end
endmodule

// File: tb/tb_minitb_ahb_slave.sv
// Scoreboarded bench for minitb_ahb_slave at waitStates 0, 2 and 3.
// A pipelined driver pushes expectations at the address phase and checks them at completion.
module tb_minitb_ahb_slave;
    typedef struct {
        logic [1:0]  trans;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } cmd_t;

    typedef struct {
        logic        resp;
        logic [31:0] rdata;
        int          waits;
    } exp_t;

    logic        hclk = 1'b0;
    logic        hreset [3];
    logic [1:0]  htrans [3];
    logic [7:0]  haddr  [3];
    logic        hwrite [3];
    logic [31:0] hwdata [3];
    logic        hready [3];
    logic        hresp  [3];
    logic [31:0] hrdata [3];

    int          ws_of [3] = '{0, 2, 3};
    logic [31:0] model [3][16];
    exp_t        sb [$];
    int          n_chk = 0;
    int          n_err = 0;

    always #5 hclk = ~hclk;

    minitb_ahb_slave #(.waitStates(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset[0]), .htrans(htrans[0]), .haddr(haddr[0]), .hwrite(hwrite[0]),
        .hwdata(hwdata[0]), .hready(hready[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));
    minitb_ahb_slave #(.waitStates(2)) u_ws2 (
        .hclk(hclk), .hreset(hreset[1]), .htrans(htrans[1]), .haddr(haddr[1]), .hwrite(hwrite[1]),
        .hwdata(hwdata[1]), .hready(hready[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));
    minitb_ahb_slave #(.waitStates(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset[2]), .htrans(htrans[2]), .haddr(haddr[2]), .hwrite(hwrite[2]),
        .hwdata(hwdata[2]), .hready(hready[2]), .hresp(hresp[2]), .hrdata(hrdata[2]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    function automatic cmd_t mk(input logic [1:0] t, input logic w, input logic [7:0] a, input logic [31:0] d);
        cmd_t c;
        c.trans = t; c.wr = w; c.addr = a; c.data = d;
        return c;
    endfunction

    task automatic check_reset_state(input int d);
        check("rst_hready", hready[d], 1);
        check("rst_hresp",  hresp[d],  0);
        check("rst_hrdata", hrdata[d], 0);
    endtask

    task automatic clear_model(input int d);
        for (int a = 0; a < 16; a++) model[d][a] = '0;
    endtask

    // Drives cmds back to back on DUT d, sampling at the falling edge.
    task automatic run(input int d, input cmd_t cmds[$]);
        int   i = 0;
        bit   inf_v = 0;
        cmd_t inf;
        int   waits = 0;
        exp_t e;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge hclk);
            if (!inf_v) begin
                check("idle_hready", hready[d], 1);
                check("idle_hresp",  hresp[d],  0);
                check("idle_hrdata", hrdata[d], 0);
            end else if (!hready[d]) begin
                waits++;
                hwdata[d] = $urandom;
                check("wait_hresp",  hresp[d],  sb[0].resp);
                check("wait_hrdata", hrdata[d], 0);
                continue;
            end else begin
                e = sb.pop_front();
                hwdata[d] = inf.wr ? inf.data : $urandom;
                check($sformatf("resp@%0h", inf.addr),  hresp[d],  e.resp);
                check($sformatf("rdata@%0h", inf.addr), hrdata[d], e.rdata);
                check($sformatf("waits@%0h", inf.addr), waits,     e.waits);
            end
            waits = 0;
            if (i == cmds.size()) begin
                htrans[d] = 2'b00;
                return;
            end
            inf = cmds[i];
            i++;
            htrans[d] = inf.trans;
            haddr[d]  = inf.addr;
            hwrite[d] = inf.wr;
            inf_v     = inf.trans[1];
            if (inf_v) begin
                e.resp  = (inf.addr >= 8'd16);
                e.waits = e.resp ? 1 : ws_of[d];
                e.rdata = (!e.resp && !inf.wr) ? model[d][inf.addr[3:0]] : 32'h0;
                if (!e.resp && inf.wr) model[d][inf.addr[3:0]] = inf.data;
                sb.push_back(e);
            end
        end
        check("run_timeout", 0, 1);
    endtask

    initial begin
        cmd_t q[$];
        for (int d = 0; d < 3; d++) begin
            hreset[d] = 1'b1; htrans[d] = 2'b00; haddr[d] = '0; hwrite[d] = 1'b0; hwdata[d] = '0;
            clear_model(d);
        end
        repeat (2) @(negedge hclk);
        for (int d = 0; d < 3; d++) begin
            check_reset_state(d);
            hreset[d] = 1'b0;
        end

        // Zero wait states: pipelined write then read relies on forwarding.
        q = {};
        q.push_back(mk(2'b10, 1, 8'h03, 32'hDEADBEEF));
        q.push_back(mk(2'b11, 0, 8'h03, 32'h0));
        q.push_back(mk(2'b10, 1, 8'h00, 32'h11111111));
        q.push_back(mk(2'b11, 1, 8'h0F, 32'h0F0F0F0F));
        q.push_back(mk(2'b10, 0, 8'h00, 32'h0));
        q.push_back(mk(2'b11, 0, 8'h0F, 32'h0));
        q.push_back(mk(2'b11, 0, 8'h03, 32'h0));
        run(0, q);

        // Mid-simulation reset clears outputs immediately and memory.
        @(negedge hclk);
        #2 hreset[0] = 1'b1;
        #1 check_reset_state(0);
        @(negedge hclk) hreset[0] = 1'b0;
        clear_model(0);
        q = {};
        q.push_back(mk(2'b10, 0, 8'h00, 32'h0));
        q.push_back(mk(2'b10, 0, 8'h03, 32'h0));
        run(0, q);

        // Two wait states, then out-of-range writes at and past the boundary.
        q = {};
        q.push_back(mk(2'b10, 1, 8'h05, 32'h12345678));
        q.push_back(mk(2'b10, 0, 8'h05, 32'h0));
        q.push_back(mk(2'b10, 1, 8'h20, 32'hFFFFFFFF));
        q.push_back(mk(2'b10, 1, 8'h10, 32'hFFFFFFFF));
        q.push_back(mk(2'b10, 1, 8'h0F, 32'hCAFEF00D));
        q.push_back(mk(2'b10, 0, 8'hFF, 32'h0));
        for (int a = 0; a < 16; a++) q.push_back(mk(2'b10, 0, 8'(a), 32'h0));
        run(1, q);

        // BUSY and IDLE with live-looking address/write must be ignored.
        q = {};
        q.push_back(mk(2'b01, 1, 8'h05, 32'hBADBAD01));
        q.push_back(mk(2'b00, 1, 8'h0F, 32'hBADBAD02));
        q.push_back(mk(2'b01, 1, 8'h20, 32'hBADBAD03));
        q.push_back(mk(2'b10, 0, 8'h05, 32'h0));
        q.push_back(mk(2'b10, 0, 8'h0F, 32'h0));
        run(1, q);

        // Three wait states: reset during the second wait cycle of a write.
        @(negedge hclk);
        htrans[2] = 2'b10; haddr[2] = 8'h07; hwrite[2] = 1'b1; hwdata[2] = $urandom;
        @(negedge hclk);
        htrans[2] = 2'b00;
        check("ws3_wait1_hready", hready[2], 0);
        @(negedge hclk);
        hwdata[2] = 32'hA5A5A5A5;
        check("ws3_wait2_hready", hready[2], 0);
        #2 hreset[2] = 1'b1;
        #1 check_reset_state(2);
        @(negedge hclk) hreset[2] = 1'b0;
        clear_model(2);
        q = {};
        q.push_back(mk(2'b10, 0, 8'h07, 32'h0));
        q.push_back(mk(2'b10, 1, 8'h02, 32'h5A5A5A5A));
        q.push_back(mk(2'b10, 0, 8'h02, 32'h0));
        run(2, q);

        repeat (2) @(negedge hclk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
